// File: rtl/param_ram_pkg.sv
// Shared definitions for the parameterised single-port RAM with clear sweep.
// Holds the controller state encoding and the default geometry.
package param_ram_pkg;

  localparam int DEFAULT_DATA_W = 4;
  localparam int DEFAULT_DEPTH  = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/param_ram_array.sv
// Storage array for param_ram: synchronous write, combinational read, no reset.
// Out-of-range read addresses return zero so non-power-of-two depths never index past the array.
module param_ram_array
  import param_ram_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wAddr,
  input  logic [DATA_W-1:0] i_wData,
  input  logic [ADDR_W-1:0] i_rAddr,
  output logic [DATA_W-1:0] o_rData
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wAddr] <= i_wData;
  end

  always_comb begin
    o_rData = '0;
    if ({1'b0, i_rAddr} < (ADDR_W+1)'(DEPTH)) o_rData = r_mem[i_rAddr];
  end

endmodule

// File: rtl/param_ram.sv
// Single-port RAM controller: zero-fill sweep after reset or clear request, then
// one read or write per cycle with range checking and a registered read port.
module param_ram
  import param_ram_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr_req,
  output logic              ready,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              err
);

  state_t            r_state, w_nextState;
  logic [ADDR_W-1:0] r_sweepAddr, w_nextSweepAddr;
  logic [DATA_W-1:0] r_dataOut;
  logic              r_rdValid, r_err;

  logic              w_inRange, w_lastSweep, w_reqAccept;
  logic              w_memWe;
  logic [ADDR_W-1:0] w_memAddr;
  logic [DATA_W-1:0] w_memWData, w_memRData;

  assign ready       = (r_state == IDLE);
  assign w_inRange   = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
  assign w_lastSweep = (r_sweepAddr == ADDR_W'(DEPTH - 1));
  // A clear request takes priority over any access presented on the same edge.
  assign w_reqAccept = ready & req & ~clr_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= CLEAR;
      r_sweepAddr <= '0;
    end else begin
      r_state     <= w_nextState;
      r_sweepAddr <= w_nextSweepAddr;
    end
  end

  always_comb begin
    w_nextState     = r_state;
    w_nextSweepAddr = r_sweepAddr;
    w_memWe         = 1'b0;
    w_memAddr       = addr;
    w_memWData      = data_in;
    case (r_state)
      CLEAR: begin
        w_memWe    = 1'b1;
        w_memAddr  = r_sweepAddr;
        w_memWData = '0;
        if (w_lastSweep) begin
          w_nextState     = IDLE;
          w_nextSweepAddr = '0;
        end else begin
          w_nextSweepAddr = r_sweepAddr + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (clr_req) begin
          w_nextState     = CLEAR;
          w_nextSweepAddr = '0;
        end else if (req && we && w_inRange) begin
          w_memWe = 1'b1;
        end
      end
      default: w_nextState = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dataOut <= '0;
      r_rdValid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rdValid <= w_reqAccept & ~we & w_inRange;
      r_err     <= w_reqAccept & ~w_inRange;
      if (w_reqAccept && !we && w_inRange) r_dataOut <= w_memRData;
    end
  end

  param_ram_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk    (clk),
    .i_we   (w_memWe),
    .i_wAddr(w_memAddr),
    .i_wData(w_memWData),
    .i_rAddr(addr),
    .o_rData(w_memRData)
  );

  assign data_out = r_dataOut;
  assign rd_valid = r_rdValid;
  assign err      = r_err;

endmodule
